// File: rtl/process_element.sv
// Signed fixed-point multiply-accumulate element: Yout <= Yin + (weight*Xin >>> FRAC_W), one-cycle latency.
// Define PE_SATURATE_EN to clamp out-of-range sums; otherwise results wrap in two's complement.
module process_element #(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned FRAC_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] weight,
  input  logic [DATA_W-1:0] Xin,
  input  logic [DATA_W-1:0] Yin,
  output logic [DATA_W-1:0] Yout
);

  localparam int unsigned PROD_W = 2 * DATA_W;
  localparam int unsigned SUM_W  = 2 * DATA_W + 1;

  logic signed [PROD_W-1:0] prod_c;
  logic signed [PROD_W-1:0] prod_shift_c;
  logic signed [SUM_W-1:0]  sum_c;
  logic        [DATA_W-1:0] yout_next_c;

  // Full-precision product, floor-rescaled, then added to the incoming partial sum
  always_comb begin
    prod_c       = PROD_W'($signed(weight)) * PROD_W'($signed(Xin));
    prod_shift_c = prod_c >>> FRAC_W;
    sum_c        = SUM_W'(prod_shift_c) + SUM_W'($signed(Yin));
  end

`ifdef PE_SATURATE_EN
  logic all_zero_c;
  logic all_one_c;

  // The sum fits iff every bit above the result sign bit matches the overall sign
  always_comb begin
    all_zero_c  = ~|sum_c[SUM_W-1:DATA_W-1];
    all_one_c   = &sum_c[SUM_W-1:DATA_W-1];
    yout_next_c = sum_c[DATA_W-1:0];
    if (!sum_c[SUM_W-1] && !all_zero_c) begin
      yout_next_c = {1'b0, {(DATA_W-1){1'b1}}};
    end else if (sum_c[SUM_W-1] && !all_one_c) begin
      yout_next_c = {1'b1, {(DATA_W-1){1'b0}}};
    end
  end
`else
  logic unused_hi_c;

  always_comb begin
    yout_next_c = sum_c[DATA_W-1:0];
    unused_hi_c = ^sum_c[SUM_W-1:DATA_W];
  end
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      Yout <= '0;
    end else begin
      Yout <= yout_next_c;
    end
  end

endmodule

// File: tb/tb_process_element.sv
// Randomized and directed bench for process_element, checked against an integer model.
// Expected overflow results follow PE_SATURATE_EN when it is defined for the build.
module tb_process_element;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] weight = '0;
  logic [15:0] x_in = '0;
  logic [15:0] y_in = '0;
  logic [15:0] y_out;
  logic [15:0] chain_y [0:5];

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  process_element #(.DATA_W(16), .FRAC_W(8)) dut (
    .clk(clk), .rst(rst), .weight(weight), .Xin(x_in), .Yin(y_in), .Yout(y_out)
  );

  // Five-tap row built from the same element
  assign chain_y[0] = 16'h0000;
  for (genvar g = 0; g < 5; g++) begin : g_chain
    process_element #(.DATA_W(16), .FRAC_W(8)) pe (
      .clk(clk), .rst(rst), .weight(16'h0100), .Xin(16'h0100),
      .Yin(chain_y[g]), .Yout(chain_y[g+1])
    );
  end

  // Reference: exact integer arithmetic, floor division by 2^8, then clamp or wrap
  function automatic logic [15:0] pe_model(input logic [15:0] w, input logic [15:0] x,
                                           input logic [15:0] y);
    longint p;
    longint s;
    p = longint'($signed(w)) * longint'($signed(x));
    s = (p >>> 8) + longint'($signed(y));
`ifdef PE_SATURATE_EN
    if (s > 32767) s = 32767;
    if (s < -32768) s = -32768;
`endif
    return 16'(s);
  endfunction

  task automatic drive(input logic [15:0] w, input logic [15:0] x, input logic [15:0] y);
    weight = w;
    x_in   = x;
    y_in   = y;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    drive(16'h0100, 16'h0200, 16'h0080);
    #2;
    n_checks++;
    if (y_out !== 16'h0000) begin
      n_fail++;
      $display("FAIL reset_initial: got %h want 0000", y_out);
    end
    tick();
    n_checks++;
    if (y_out !== 16'h0000) begin
      n_fail++;
      $display("FAIL reset_held_over_edge: got %h want 0000", y_out);
    end
    rst = 1'b0;
    tick();
    n_checks++;
    if (y_out !== 16'h0280) begin
      n_fail++;
      $display("FAIL reset_first_result: got %h want 0280", y_out);
    end
    rst = 1'b1;
    #1;
    n_checks++;
    if (y_out !== 16'h0000) begin
      n_fail++;
      $display("FAIL reset_async_midcycle: got %h want 0000", y_out);
    end
    drive(16'hFF00, 16'h0300, 16'h0000);
    #1;
    rst = 1'b0;
    tick();
    n_checks++;
    if (y_out !== 16'hFD00) begin
      n_fail++;
      $display("FAIL reset_recovery_negative: got %h want fd00", y_out);
    end
  endtask

  task automatic test_directed();
    logic [15:0] w_tab   [0:4] = '{16'hFF00, 16'hFFFF, 16'h0001, 16'h7FFF, 16'h8000};
    logic [15:0] x_tab   [0:4] = '{16'h0300, 16'h0080, 16'h0080, 16'h7FFF, 16'h7FFF};
    logic [15:0] y_tab   [0:4] = '{16'h0000, 16'h0000, 16'h0000, 16'h7FFF, 16'h8000};
`ifdef PE_SATURATE_EN
    logic [15:0] exp_tab [0:4] = '{16'hFD00, 16'hFFFF, 16'h0000, 16'h7FFF, 16'h8000};
`else
    logic [15:0] exp_tab [0:4] = '{16'hFD00, 16'hFFFF, 16'h0000, 16'h7EFF, 16'h8080};
`endif
    for (int i = 0; i < 5; i++) begin
      drive(w_tab[i], x_tab[i], y_tab[i]);
      tick();
      n_checks++;
      if (y_out !== exp_tab[i]) begin
        n_fail++;
        $display("FAIL directed_%0d (w=%h x=%h y=%h): got %h want %h",
                 i, w_tab[i], x_tab[i], y_tab[i], y_out, exp_tab[i]);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [15:0] w, x, y, exp_y;
    for (int i = 0; i < 300; i++) begin
      w = 16'($urandom);
      x = 16'($urandom);
      y = 16'($urandom);
      // Keep a share of small operands so in-range results are well exercised
      if (i % 3 == 0) begin
        w = 16'($signed(16'($urandom_range(0, 1023))) - 16'sd512);
        x = 16'($signed(16'($urandom_range(0, 1023))) - 16'sd512);
      end
      drive(w, x, y);
      exp_y = pe_model(w, x, y);
      tick();
      n_checks++;
      if (y_out !== exp_y) begin
        n_fail++;
        $display("FAIL stream_%0d (w=%h x=%h y=%h): got %h want %h", i, w, x, y, y_out, exp_y);
      end
    end
  endtask

  task automatic test_chain();
    logic [15:0] exp_y;
    rst = 1'b1;
    #1;
    n_checks++;
    if (chain_y[5] !== 16'h0000) begin
      n_fail++;
      $display("FAIL chain_reset: got %h want 0000", chain_y[5]);
    end
    rst = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      tick();
      exp_y = 16'((k < 5 ? k : 5) * 256);
      n_checks++;
      if (chain_y[5] !== exp_y) begin
        n_fail++;
        $display("FAIL chain_edge_%0d: got %h want %h", k, chain_y[5], exp_y);
      end
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_back_to_back();
    test_chain();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
